// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding
// and the identifiers used for the instruction and data ports.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        REL    = 2'd3
    } state_t;

    // Port identifiers double as bit positions in the request vector.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick. On a tie the requester that was not
// granted last wins; a lone requester always wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Pick the winner among the current requesters.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = PORT_I;
        if (req[PORT_I] && req[PORT_D]) begin
            gnt_id = ~last_grant;
        end else if (req[PORT_D]) begin
            gnt_id = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory between an instruction-cache port and a data-cache
// port. The state register is the only record of who owns the memory; each
// completed transaction is followed by one release cycle, then IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    // instruction-cache port
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    // data-cache port
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    // memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    // statistics
    output logic [CNT_W-1:0]  stat_i_cnt,
    output logic [CNT_W-1:0]  stat_d_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;
    state_t next_state;
    logic   last_grant;
    logic   gnt_valid;
    logic   gnt_id;
    logic   i_req;
    logic   d_req;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;

    // Read data goes straight through to both caches.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    rr_arb2 u_rr_arb2 (
        .req        ({d_req, i_req}),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // State register and round-robin history; D is "last" after reset so I wins the first tie.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (!proc_reset_n) begin
            state      <= IDLE;
            last_grant <= PORT_D;
        end else begin
            state <= next_state;
            if (state == BUSY_I && mem_ready) begin
                last_grant <= PORT_I;
            end else if (state == BUSY_D && mem_ready) begin
                last_grant <= PORT_D;
            end
        end
    end

    // Next-state: grant from IDLE, finish or abandon in BUSY, always one REL cycle.
    always_comb begin
        // NOTE: default first so no path through the case leaves next_state unassigned (no latch).
        next_state = state;
        unique case (state)
            IDLE: begin
                if (gnt_valid) begin
                    next_state = (gnt_id == PORT_I) ? BUSY_I : BUSY_D;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    next_state = REL;
                end else if (!i_req) begin
                    next_state = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    next_state = REL;
                end else if (!d_req) begin
                    next_state = IDLE;
                end
            end
            REL:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs: mirror the owning port while busy, everything quiet otherwise.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        unique case (state)
            BUSY_I: begin
                mem_write = i_write;
                mem_read  = i_read & ~i_write;
                mem_addr  = i_addr;
                mem_wdata = i_wdata;
                i_ready   = mem_ready;
            end
            BUSY_D: begin
                mem_write = d_write;
                mem_read  = d_read & ~d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_ready   = mem_ready;
            end
            default: begin
            end
        endcase
    end

    // Saturating completion counters, bumped on the cycle memory reports done.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            stat_i_cnt <= '0;
            stat_d_cnt <= '0;
        end else begin
            if (state == BUSY_I && mem_ready && stat_i_cnt != '1) begin
                stat_i_cnt <= stat_i_cnt + CNT_ONE;
            end
            if (state == BUSY_D && mem_ready && stat_d_cnt != '1) begin
                stat_d_cnt <= stat_d_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change and outputs are sampled
// 1 time unit after the rising edge. The counter width is narrowed here so
// that the saturation scenario reaches all-ones in a few hundred cycles.
module tb_mem_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 8;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic              clk;
    logic              proc_reset_n;
    logic              i_read, i_write, d_read, d_write;
    logic [ADDR_W-1:0] i_addr, d_addr, mem_addr;
    logic [DATA_W-1:0] i_wdata, d_wdata, mem_wdata;
    logic [DATA_W-1:0] i_rdata, d_rdata, mem_rdata;
    logic              i_ready, d_ready, mem_read, mem_write, mem_ready;
    logic [CNT_W-1:0]  stat_i_cnt, stat_d_cnt;
    logic [3:0]        ctl;

    int vectors     = 0;
    int miscompares = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .i_read       (i_read),
        .i_write      (i_write),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_ready      (i_ready),
        .i_rdata      (i_rdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_ready      (d_ready),
        .d_rdata      (d_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .stat_i_cnt   (stat_i_cnt),
        .stat_d_cnt   (stat_d_cnt)
    );

    // {mem_read, mem_write, i_ready, d_ready}
    assign ctl = {mem_read, mem_write, i_ready, d_ready};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_read = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        proc_reset_n = 1'b0;
        tick();
        proc_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        proc_reset_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({ctl, mem_addr, mem_wdata, i_rdata, d_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: ctl=%b addr=%h wdata=%h, required all zero", ctl, mem_addr, mem_wdata);
        end
        vectors++;
        if ({stat_i_cnt, stat_d_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_counters: i=%h d=%h, required 0 0", stat_i_cnt, stat_d_cnt);
        end
        // requests and mem_ready during reset must not produce any activity
        i_read = 1'b1; mem_ready = 1'b1;
        tick();
        vectors++;
        if (ctl !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_held: ctl=%b, required 0000", ctl);
        end
        clear_inputs();
        proc_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        int pulses = 0;
        do_reset();
        i_read = 1'b1; i_addr = 28'h0000010;
        #1;
        vectors++;
        if (ctl !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_idle: ctl=%b, required 0000", ctl);
        end
        tick();
        for (int cyc = 0; cyc < 3; cyc++) begin
            mem_ready = (cyc == 2);
            #1;
            pulses += int'(i_ready);
            vectors++;
            if ({ctl, mem_addr} !== {1'b1, 1'b0, (cyc == 2), 1'b0, 28'h0000010}) begin
                miscompares++;
                $display("FAIL single_busy%0d: ctl=%b addr=%h, required %b0 addr 0000010", cyc, ctl, mem_addr, {1'b1, 1'b0, (cyc == 2)});
            end
            if (cyc < 2) tick();
        end
        tick();
        i_read = 1'b0; mem_ready = 1'b0;
        #1;
        pulses += int'(i_ready);
        vectors++;
        if ({ctl, mem_addr} !== '0) begin
            miscompares++;
            $display("FAIL single_rel: ctl=%b addr=%h, required zero", ctl, mem_addr);
        end
        vectors++;
        if (stat_i_cnt !== 8'd1 || stat_d_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL single_count: i=%0d d=%0d, required 1 0", stat_i_cnt, stat_d_cnt);
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL single_pulses: i_ready pulses=%0d, required 1", pulses);
        end
        tick();
    endtask

    task automatic test_tie();
        do_reset();
        i_read = 1'b1; i_addr = 28'h0000111;
        d_read = 1'b1; d_addr = 28'h0000222;
        tick();
        vectors++;
        if ({ctl, mem_addr} !== {4'b1000, 28'h0000111}) begin
            miscompares++;
            $display("FAIL tie_first: ctl=%b addr=%h, required 1000 addr 0000111", ctl, mem_addr);
        end
        mem_ready = 1'b1;
        #1;
        vectors++;
        if (ctl !== 4'b1010) begin
            miscompares++;
            $display("FAIL tie_first_ready: ctl=%b, required 1010", ctl);
        end
        tick();
        mem_ready = 1'b0;
        #1;
        vectors++;
        if ({ctl, mem_addr} !== '0) begin
            miscompares++;
            $display("FAIL tie_rel: ctl=%b addr=%h, required zero", ctl, mem_addr);
        end
        tick();
        vectors++;
        if (ctl !== 4'b0000) begin
            miscompares++;
            $display("FAIL tie_idle: ctl=%b, required 0000", ctl);
        end
        tick();
        vectors++;
        if ({ctl, mem_addr} !== {4'b1000, 28'h0000222}) begin
            miscompares++;
            $display("FAIL tie_second: ctl=%b addr=%h, required 1000 addr 0000222", ctl, mem_addr);
        end
        mem_ready = 1'b1;
        #1;
        vectors++;
        if (ctl !== 4'b1001) begin
            miscompares++;
            $display("FAIL tie_second_ready: ctl=%b, required 1001", ctl);
        end
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (stat_i_cnt !== 8'd1 || stat_d_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL tie_counts: i=%0d d=%0d, required 1 1", stat_i_cnt, stat_d_cnt);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] wd = 128'hDEADBEEF_00000000_00000000_00000001;
        logic [DATA_W-1:0] rd = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        do_reset();
        d_write = 1'b1; d_addr = 28'h0000ABC; d_wdata = wd;
        tick();
        vectors++;
        if ({ctl, mem_addr, mem_wdata} !== {4'b0100, 28'h0000ABC, wd}) begin
            miscompares++;
            $display("FAIL b2b_write: ctl=%b addr=%h wdata=%h, required 0100 0000abc %h", ctl, mem_addr, mem_wdata, wd);
        end
        mem_ready = 1'b1;
        #1;
        vectors++;
        if (ctl !== 4'b0101) begin
            miscompares++;
            $display("FAIL b2b_write_ready: ctl=%b, required 0101", ctl);
        end
        tick();
        d_write = 1'b0; d_read = 1'b1; d_addr = 28'h0000ABD; mem_ready = 1'b0;
        #1;
        vectors++;
        if ({ctl, mem_addr, mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL b2b_rel: ctl=%b addr=%h wdata=%h, required zero", ctl, mem_addr, mem_wdata);
        end
        tick();
        vectors++;
        if (ctl !== 4'b0000) begin
            miscompares++;
            $display("FAIL b2b_idle: ctl=%b, required 0000", ctl);
        end
        tick();
        mem_rdata = rd; mem_ready = 1'b1;
        #1;
        vectors++;
        if ({ctl, mem_addr} !== {4'b1001, 28'h0000ABD}) begin
            miscompares++;
            $display("FAIL b2b_read: ctl=%b addr=%h, required 1001 addr 0000abd", ctl, mem_addr);
        end
        vectors++;
        if (i_rdata !== rd || d_rdata !== rd) begin
            miscompares++;
            $display("FAIL b2b_rdata: i=%h d=%h, required %h", i_rdata, d_rdata, rd);
        end
        tick();
        clear_inputs();
        #1;
        vectors++;
        if ({ctl, stat_i_cnt, stat_d_cnt} !== {4'b0000, 8'd0, 8'd2}) begin
            miscompares++;
            $display("FAIL b2b_end: ctl=%b i=%0d d=%0d, required 0000 0 2", ctl, stat_i_cnt, stat_d_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        d_read = 1'b1; d_addr = 28'h0000333;
        tick();
        vectors++;
        if ({ctl, mem_addr} !== {4'b1000, 28'h0000333}) begin
            miscompares++;
            $display("FAIL rst_busy: ctl=%b addr=%h, required 1000 addr 0000333", ctl, mem_addr);
        end
        #2;
        proc_reset_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        vectors++;
        if ({ctl, mem_addr, stat_i_cnt, stat_d_cnt} !== '0) begin
            miscompares++;
            $display("FAIL rst_immediate: ctl=%b addr=%h i=%0d d=%0d, required all zero", ctl, mem_addr, stat_i_cnt, stat_d_cnt);
        end
        tick();
        proc_reset_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        vectors++;
        if ({ctl, stat_d_cnt} !== '0) begin
            miscompares++;
            $display("FAIL rst_after: ctl=%b d=%0d, required 0000 0", ctl, stat_d_cnt);
        end
        tick();
        mem_ready = 1'b1;
        #1;
        vectors++;
        if ({ctl, mem_addr} !== {4'b1001, 28'h0000333}) begin
            miscompares++;
            $display("FAIL rst_next_req: ctl=%b addr=%h, required 1001 addr 0000333", ctl, mem_addr);
        end
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (stat_d_cnt !== 8'd1 || stat_i_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL rst_next_count: i=%0d d=%0d, required 0 1", stat_i_cnt, stat_d_cnt);
        end
        tick();
    endtask

    task automatic test_read_write_together();
        do_reset();
        i_read = 1'b1; i_write = 1'b1; i_addr = 28'h0000444; i_wdata = 128'h55;
        tick();
        vectors++;
        if ({ctl, mem_wdata} !== {4'b0100, 128'h55}) begin
            miscompares++;
            $display("FAIL rw_busy: ctl=%b wdata=%h, required 0100 wdata 55", ctl, mem_wdata);
        end
        mem_ready = 1'b1;
        #1;
        vectors++;
        if (ctl !== 4'b0110) begin
            miscompares++;
            $display("FAIL rw_ready: ctl=%b, required 0110", ctl);
        end
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (stat_i_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL rw_count: i=%0d, required 1", stat_i_cnt);
        end
        tick();
    endtask

    task automatic test_saturation();
        int pulses = 0;
        do_reset();
        i_read = 1'b1; i_addr = 28'h0000010; mem_ready = 1'b1;
        // Each transaction takes BUSY_I, REL, IDLE: three cycles.
        for (int k = 0; k < 3 * (MAXC - 1); k++) begin
            tick();
            pulses += int'(i_ready);
        end
        vectors++;
        if (stat_i_cnt !== 8'(MAXC - 1) || pulses != MAXC - 1) begin
            miscompares++;
            $display("FAIL sat_before: cnt=%0d pulses=%0d, required %0d %0d", stat_i_cnt, pulses, MAXC - 1, MAXC - 1);
        end
        for (int k = 0; k < 9; k++) begin
            tick();
            pulses += int'(i_ready);
        end
        vectors++;
        if (stat_i_cnt !== 8'(MAXC) || pulses != MAXC + 2) begin
            miscompares++;
            $display("FAIL sat_hold: cnt=%0d pulses=%0d, required %0d %0d", stat_i_cnt, pulses, MAXC, MAXC + 2);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    initial begin
        clear_inputs();
        proc_reset_n = 1'b0;
        test_reset();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_reset_mid_busy();
        test_read_write_together();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
